// File: rtl/flag_pkg.sv
// Shared types for the flag/branch unit: ALU opcodes, branch kinds, LEGv8
// condition codes and the architectural {N,Z,C,V} flag record.
package flag_pkg;

  typedef enum logic [2:0] {
    ALU_BYPASSA = 3'd0,
    ALU_BYPASSB = 3'd1,
    ALU_ADD     = 3'd2,
    ALU_SUB     = 3'd3,
    ALU_NOT     = 3'd4,
    ALU_AND     = 3'd5,
    ALU_ORR     = 3'd6,
    ALU_XOR     = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    BR_B    = 2'd0,
    BR_COND = 2'd1,
    BR_CBZ  = 2'd2,
    BR_CBNZ = 2'd3
  } br_kind_e;

  typedef enum logic [3:0] {
    COND_EQ = 4'd0,  COND_NE = 4'd1,  COND_HS = 4'd2,  COND_LO = 4'd3,
    COND_MI = 4'd4,  COND_PL = 4'd5,  COND_VS = 4'd6,  COND_VC = 4'd7,
    COND_HI = 4'd8,  COND_LS = 4'd9,  COND_GE = 4'd10, COND_LT = 4'd11,
    COND_GT = 4'd12, COND_LE = 4'd13, COND_AL = 4'd14, COND_NV = 4'd15
  } cond_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  // Only arithmetic ops produce meaningful carry/overflow.
  function automatic logic sets_cv(alu_op_e op);
    return (op == ALU_ADD) || (op == ALU_SUB);
  endfunction

endpackage

// File: rtl/cond_eval.sv
// Combinational LEGv8 condition-code evaluator over a flag record.
module cond_eval
  import flag_pkg::*;
(
  input  flags_t i_flags,
  input  cond_e  i_cond,
  output logic   o_taken
);

  always_comb begin
    // NOTE: default first so every path assigns o_taken and no latch is inferred.
    o_taken = 1'b1;
    case (i_cond)
      COND_EQ: o_taken = i_flags.z;
      COND_NE: o_taken = !i_flags.z;
      COND_HS: o_taken = i_flags.c;
      COND_LO: o_taken = !i_flags.c;
      COND_MI: o_taken = i_flags.n;
      COND_PL: o_taken = !i_flags.n;
      COND_VS: o_taken = i_flags.v;
      COND_VC: o_taken = !i_flags.v;
      COND_HI: o_taken = i_flags.c && !i_flags.z;
      COND_LS: o_taken = !i_flags.c || i_flags.z;
      COND_GE: o_taken = (i_flags.n == i_flags.v);
      COND_LT: o_taken = (i_flags.n != i_flags.v);
      COND_GT: o_taken = !i_flags.z && (i_flags.n == i_flags.v);
      COND_LE: o_taken = i_flags.z || (i_flags.n != i_flags.v);
      default: o_taken = 1'b1;  // AL and NV
    endcase
  end

endmodule

// File: rtl/flag_branch_unit.sv
// Condition-flag register, in-flight flag-setter tracking and registered
// branch resolution with same-cycle writeback forwarding.
module flag_branch_unit
  import flag_pkg::*;
#(
  parameter int MAX_PENDING = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       fs_issue,
  output logic       fs_ready,
  input  logic       wb_valid,
  input  logic [2:0] wb_ctrl,
  input  logic       wb_negative,
  input  logic       wb_zero,
  input  logic       wb_overflow,
  input  logic       wb_cout,
  input  logic       br_valid,
  input  logic [1:0] br_kind,
  input  logic [3:0] br_cond,
  input  logic       br_operand_zero,
  output logic       br_ready,
  output logic       br_resp_valid,
  output logic       br_taken,
  output logic [3:0] flags_q
);

  localparam int PW = $clog2(MAX_PENDING + 1);
  localparam logic [PW-1:0] PEND_MAX = PW'(MAX_PENDING);
  localparam logic [PW-1:0] PEND_ONE = PW'(1);

  logic [PW-1:0] r_pend;
  flags_t        r_flags;
  logic          r_resp_valid;
  logic          r_taken;

  flags_t   w_eff;
  br_kind_e w_kind;
  alu_op_e  w_op;
  logic     w_inc;
  logic     w_dec;
  logic     w_cond_taken;
  logic     w_taken;
  logic     w_accept;

  assign w_kind = br_kind_e'(br_kind);
  assign w_op   = alu_op_e'(wb_ctrl);

  // Flags as they will be after this cycle's writeback; branches read these.
  always_comb begin
    w_eff = r_flags;
    if (wb_valid) begin
      w_eff.n = wb_negative;
      w_eff.z = wb_zero;
      if (sets_cv(w_op)) begin
        w_eff.c = wb_cout;
        w_eff.v = wb_overflow;
      end
    end
  end

  cond_eval u_cond_eval (
    .i_flags (w_eff),
    .i_cond  (cond_e'(br_cond)),
    .o_taken (w_cond_taken)
  );

  assign fs_ready = (r_pend < PEND_MAX);
  assign w_inc    = fs_issue && fs_ready;
  assign w_dec    = wb_valid && (r_pend != '0);

  // A same-cycle issue is younger than the branch, so only the registered count matters.
  always_comb begin
    br_ready = 1'b1;
    w_taken  = 1'b1;
    case (w_kind)
      BR_COND: begin
        br_ready = (r_pend == '0) || ((r_pend == PEND_ONE) && wb_valid);
        w_taken  = w_cond_taken;
      end
      BR_CBZ:  w_taken = br_operand_zero;
      BR_CBNZ: w_taken = !br_operand_zero;
      default: w_taken = 1'b1;
    endcase
  end

  assign w_accept = br_valid && br_ready;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pend       <= '0;
      r_flags      <= '0;
      r_resp_valid <= 1'b0;
      r_taken      <= 1'b0;
    end else begin
      if (w_inc && !w_dec) begin
        r_pend <= r_pend + PEND_ONE;
      end else if (w_dec && !w_inc) begin
        r_pend <= r_pend - PEND_ONE;
      end
      r_flags      <= w_eff;
      r_resp_valid <= w_accept;
      r_taken      <= w_accept && w_taken;
    end
  end

  assign flags_q       = r_flags;
  assign br_resp_valid = r_resp_valid;
  assign br_taken      = r_taken;

endmodule

// File: doc/flag_branch_unit.md
# flag_branch_unit

Consumes the N/Z/C/V flags produced by the datapath ALU, holds the architectural condition-flag register, and resolves conditional branches from decode (B, B.cond, CBZ, CBNZ) into a registered taken/not-taken response. It tracks in-flight flag-setting instructions between decode and ALU writeback. It stalls flag-dependent branches until the flags are current, and forwards same-cycle writeback flags so there is no bubble.

## Interface
Parameters:
- MAX_PENDING, default 3: maximum number of flag-setting instructions that may be in flight (issued, not yet written back).

Ports:
- clk  in  1  single clock; all state updates on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- fs_issue  in  1  decode issues an instruction that sets flags.
- fs_ready  out  1  high when the pending count is below MAX_PENDING.
- wb_valid  in  1  ALU writeback of a flag-setting instruction this cycle.
- wb_ctrl  in  3  ALU opcode of the writeback: 0 BYPASSA, 1 BYPASSB, 2 ADD, 3 SUB, 4 NOT, 5 AND, 6 ORR, 7 XOR.
- wb_negative, wb_zero, wb_overflow, wb_cout  in  1 each  ALU flag outputs.
- br_valid  in  1  branch request.
- br_kind  in  2  0 B, 1 B.cond, 2 CBZ, 3 CBNZ.
- br_cond  in  4  LEGv8 condition code; used only for B.cond.
- br_operand_zero  in  1  register operand is zero; used for CBZ/CBNZ.
- br_ready  out  1  request accepted this cycle when br_valid is also high.
- br_resp_valid  out  1  pulses one cycle after acceptance.
- br_taken  out  1  resolution; 0 whenever br_resp_valid is 0.
- flags_q  out  4  architectural flags {N,Z,C,V}.

## Operation
- Pending counter `pend`, width $clog2(MAX_PENDING+1).
  - Increments on fs_issue && fs_ready.
  - Decrements on wb_valid && pend!=0.
  - Both in the same cycle: unchanged.
  - fs_issue while full is ignored; no saturation wrap.
  - wb_valid at pend==0 still updates flags, and the count stays 0.
- Flag update on wb_valid:
  - N and Z always load.
  - C and V load only when wb_ctrl is ADD or SUB; otherwise they retain their value. The ALU's V is don't-care for other opcodes.
- Effective flags `eff` are the flags_q value after the current cycle's writeback would apply, computed combinationally.
- br_ready:
  - B, CBZ, CBNZ: always 1.
  - B.cond: 1 when pend==0, or when pend==1 && wb_valid (forwarded through `eff`); otherwise 0.
- If br_valid and fs_issue are high together, the branch is older: it evaluates against the pre-issue count.
- Conditions on `eff`:
  - EQ Z; NE !Z; HS C; LO !C.
  - MI N; PL !N; VS V; VC !V.
  - HI C&!Z; LS !C|Z.
  - GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V).
  - AL and NV are both always taken.
- CBZ is taken iff br_operand_zero; CBNZ is taken iff !br_operand_zero; B is always taken.

## Timing
- Reset (asynchronous assert, synchronous-release expectation) sets:
  - flags_q=0, pend=0, br_resp_valid=0, br_taken=0.
  - Hence fs_ready=1.
- Latency:
  - An accepted branch gives br_resp_valid/br_taken exactly 1 cycle later.
  - One accept per cycle gives back-to-back responses.
- Flags:
  - flags_q is visible the cycle after wb_valid.
  - A branch in the writeback cycle sees the new flags through forwarding.
- A stalled B.cond keeps br_ready low. The requester holds br_valid, br_kind and br_cond stable until acceptance.
- Reset during a stall clears pend. br_ready for B.cond then goes high in the first cycle after release, and no response is emitted for the aborted request.

## Structure
- Package flag_pkg holds:
  - alu_op_e, the 3-bit opcode enum matching the ALU encoding.
  - br_kind_e.
  - cond_e, the 16 LEGv8 codes.
  - flags_t, a packed struct {n,z,c,v}.
- Sub-module cond_eval is purely combinational, mapping (flags_t, cond_e) to taken. It is instantiated once on `eff`.
- The top level holds the counter, flag register, forwarding mux, and response register.

## Test plan
- Reset: assert reset_n=0 mid-run -> flags_q=4'b0000, br_resp_valid=0, fs_ready=1 immediately, without waiting for a clock edge.
- Forwarding:
  - Stimulus: fs_issue, then wb_valid SUB with wb_zero=1, wb_cout=1, N=V=0, in the same cycle as B.cond EQ.
  - Response: br_ready=1; next cycle br_taken=1 and flags_q=4'b0110.
- Stall:
  - Stimulus: two fs_issue, then B.cond GT held.
  - Response: br_ready=0 until the second wb_valid cycle.
  - With final flags N=1, V=1, Z=0 -> br_taken=1 one cycle later.
- Sticky C/V:
  - Stimulus: ADD writeback with V=1, C=0, then AND writeback with wb_overflow=0, N=0, Z=1.
  - Response: flags_q=4'b0101; a following B.cond VS is taken.
- Capacity: with MAX_PENDING=3, three issues -> fs_ready=0. A fourth issue leaves pend=3. Three writebacks and then a stray wb_valid -> pend stays 0.
- Non-flag branches:
  - CBZ with operand_zero=0 while pend=2 -> accepted immediately, br_taken=0.
  - CBNZ -> br_taken=1.
  - B -> br_taken=1.
